// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a shared 32-bit memory port.
// Grants, latches the winner's command, pulses MemStart, waits for MemDone or timeout, then acks.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqA,
    input  logic        WeA,
    input  logic [31:0] AddrA,
    input  logic [31:0] WDataA,
    input  logic        ReqB,
    input  logic        WeB,
    input  logic [31:0] AddrB,
    input  logic [31:0] WDataB,
    input  logic        MemDone,
    input  logic [31:0] MemRData,
    output logic        Sel,
    output logic        MemStart,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        AckA,
    output logic        AckB,
    output logic [31:0] RData,
    output logic        Err,
    output logic        Busy
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              last_sel_q, last_sel_d;
    logic              we_q, we_d;
    logic [DW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              start_q, start_d;
    logic              ack_a_q, ack_a_d;
    logic              ack_b_q, ack_b_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mask_a_q, mask_b_q;
    logic              req_a, req_b, win_b;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            last_sel_q <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            start_q    <= 1'b0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            mask_a_q   <= 1'b0;
            mask_b_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_sel_q <= last_sel_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            start_q    <= start_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            // A requester acked last cycle sits out the following IDLE cycle
            mask_a_q   <= ack_a_q;
            mask_b_q   <= ack_b_q;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_sel_d = last_sel_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        start_d    = 1'b0;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        req_a      = ReqA & ~mask_a_q;
        req_b      = ReqB & ~mask_b_q;
        // On a tie the requester that did not own the port last time wins
        win_b      = req_b & (~req_a | ~last_sel_q);

        case (state_q)
            S_IDLE: begin
                if (req_a || req_b) begin
                    sel_d   = win_b;
                    we_d    = win_b ? WeB    : WeA;
                    addr_d  = win_b ? AddrB  : AddrA;
                    wdata_d = win_b ? WDataB : WDataA;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (MemDone) begin
                    rdata_d = MemRData;
                    ack_a_d = ~sel_q;
                    ack_b_d = sel_q;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    ack_a_d = ~sel_q;
                    ack_b_d = sel_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                last_sel_d = sel_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign Sel      = sel_q;
    assign MemStart = start_q;
    assign MemWe    = we_q;
    assign MemAddr  = addr_q;
    assign MemWData = wdata_q;
    assign AckA     = ack_a_q;
    assign AckB     = ack_b_q;
    assign RData    = rdata_q;
    assign Err      = err_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: grant order, latency, timeout, reset abort, masking.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReqA, WeA, ReqB, WeB, MemDone;
    logic [31:0] AddrA, WDataA, AddrB, WDataB, MemRData;
    logic        Sel, MemStart, MemWe, AckA, AckB, Err, Busy;
    logic [31:0] MemAddr, MemWData, RData;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_acka = 0, n_ackb = 0, n_start = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .ReqA(ReqA), .WeA(WeA), .AddrA(AddrA), .WDataA(WDataA),
        .ReqB(ReqB), .WeB(WeB), .AddrB(AddrB), .WDataB(WDataB),
        .MemDone(MemDone), .MemRData(MemRData),
        .Sel(Sel), .MemStart(MemStart), .MemWe(MemWe), .MemAddr(MemAddr),
        .MemWData(MemWData), .AckA(AckA), .AckB(AckB), .RData(RData),
        .Err(Err), .Busy(Busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (AckA === 1'b1) n_acka <= n_acka + 1;
        if (AckB === 1'b1) n_ackb <= n_ackb + 1;
        if (MemStart === 1'b1) n_start <= n_start + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_start(input int budget, output bit ok);
        int n = 0;
        while (MemStart !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        ok = (MemStart === 1'b1);
    endtask

    task automatic clear_inputs();
        ReqA = 0; WeA = 0; AddrA = 0; WDataA = 0;
        ReqB = 0; WeB = 0; AddrB = 0; WDataB = 0;
        MemDone = 0; MemRData = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        n_vec++;
        if ({Sel, MemStart, MemWe, AckA, AckB, Err, Busy} !== 7'b0 ||
            MemAddr !== 32'h0 || MemWData !== 32'h0 || RData !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got ctl=%b addr=%h wdata=%h rdata=%h want all zero",
                     {Sel, MemStart, MemWe, AckA, AckB, Err, Busy}, MemAddr, MemWData, RData);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        bit ok;
        int c0, s0;
        s0 = n_start;
        ReqA = 1; WeA = 0; AddrA = 32'h10; WDataA = 32'h55;
        c0 = cyc;
        wait_start(10, ok);
        n_vec++;
        if (!ok || cyc - c0 != 1) begin
            n_err++;
            $display("FAIL t1_issue_latency: got ok=%0d lat=%0d want ok=1 lat=1", ok, cyc - c0);
        end
        n_vec++;
        if (Sel !== 1'b0 || MemAddr !== 32'h10 || MemWe !== 1'b0 || Busy !== 1'b1) begin
            n_err++;
            $display("FAIL t1_latch: got sel=%b addr=%h we=%b busy=%b want 0 00000010 0 1",
                     Sel, MemAddr, MemWe, Busy);
        end
        ReqA = 0;
        AddrA = 32'h99;
        tick();
        n_vec++;
        if (MemStart !== 1'b0 || MemAddr !== 32'h10) begin
            n_err++;
            $display("FAIL t1_wait1: got start=%b addr=%h want 0 00000010", MemStart, MemAddr);
        end
        tick();
        MemDone = 1; MemRData = 32'hDEADBEEF;
        tick();
        MemDone = 0;
        n_vec++;
        if (AckA !== 1'b1 || AckB !== 1'b0 || RData !== 32'hDEADBEEF || Err !== 1'b0) begin
            n_err++;
            $display("FAIL t1_done: got acka=%b ackb=%b rdata=%h err=%b want 1 0 deadbeef 0",
                     AckA, AckB, RData, Err);
        end
        tick();
        n_vec++;
        if (AckA !== 1'b0 || Busy !== 1'b0 || RData !== 32'hDEADBEEF ||
            n_start - s0 != 1 || n_ackb != 0) begin
            n_err++;
            $display("FAIL t1_after: got acka=%b busy=%b rdata=%h starts=%0d ackb=%0d want 0 0 deadbeef 1 0",
                     AckA, Busy, RData, n_start - s0, n_ackb);
        end
    endtask

    task automatic test_alternate();
        bit ok;
        int last_c;
        logic exp_sel;
        do_reset();
        ReqA = 1; WeA = 0; AddrA = 32'h100; WDataA = 32'h1;
        ReqB = 1; WeB = 1; AddrB = 32'h200; WDataB = -32'sd5;
        MemRData = 32'hCAFEF00D;
        last_c = 0;
        for (int g = 0; g < 4; g++) begin
            exp_sel = 1'(g % 2);
            wait_start(12, ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL t2_start%0d: got no MemStart want MemStart within budget", g);
            end
            n_vec++;
            if (Sel !== exp_sel || MemWe !== exp_sel ||
                MemWData !== (exp_sel ? 32'hFFFFFFFB : 32'h1)) begin
                n_err++;
                $display("FAIL t2_grant%0d: got sel=%b we=%b wdata=%h want sel=%b we=%b",
                         g, Sel, MemWe, MemWData, exp_sel, exp_sel);
            end
            if (g > 0) begin
                n_vec++;
                if (cyc - last_c != 4) begin
                    n_err++;
                    $display("FAIL t2_spacing%0d: got %0d want 4", g, cyc - last_c);
                end
            end
            last_c = cyc;
            tick();
            MemDone = 1;
            tick();
            MemDone = 0;
            n_vec++;
            if (AckA !== ~exp_sel || AckB !== exp_sel || RData !== 32'hCAFEF00D) begin
                n_err++;
                $display("FAIL t2_ack%0d: got acka=%b ackb=%b rdata=%h want acka=%b ackb=%b rdata=cafef00d",
                         g, AckA, AckB, RData, ~exp_sel, exp_sel);
            end
        end
        ReqA = 0; ReqB = 0;
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        ReqB = 1; WeB = 0; AddrB = 32'h300;
        wait_start(12, ok);
        ReqB = 0;
        tick();
        n = 0;
        while (AckB !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_vec++;
        if (!ok || n != 16) begin
            n_err++;
            $display("FAIL t3_wait_cycles: got ok=%0d n=%0d want ok=1 n=16", ok, n);
        end
        n_vec++;
        if (AckB !== 1'b1 || Err !== 1'b1 || RData !== 32'h0 || Sel !== 1'b1) begin
            n_err++;
            $display("FAIL t3_abort: got ackb=%b err=%b rdata=%h sel=%b want 1 1 00000000 1",
                     AckB, Err, RData, Sel);
        end
        tick();
        n_vec++;
        if (Err !== 1'b0 || AckB !== 1'b0) begin
            n_err++;
            $display("FAIL t3_err_clear: got err=%b ackb=%b want 0 0", Err, AckB);
        end
        ReqB = 1;
        wait_start(12, ok);
        ReqB = 0;
        tick();
        MemDone = 1; MemRData = 32'h12345678;
        tick();
        MemDone = 0;
        n_vec++;
        if (!ok || AckB !== 1'b1 || Err !== 1'b0 || RData !== 32'h12345678) begin
            n_err++;
            $display("FAIL t3_recover: got ok=%0d ackb=%b err=%b rdata=%h want 1 1 0 12345678",
                     ok, AckB, Err, RData);
        end
        tick();
    endtask

    task automatic test_done_at_timeout();
        bit ok;
        ReqA = 1; WeA = 0; AddrA = 32'h40;
        wait_start(12, ok);
        ReqA = 0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        n_vec++;
        if (!ok || AckA !== 1'b0 || Busy !== 1'b1) begin
            n_err++;
            $display("FAIL t4_wait16: got ok=%0d acka=%b busy=%b want 1 0 1", ok, AckA, Busy);
        end
        MemDone = 1; MemRData = 32'h0BADF00D;
        tick();
        MemDone = 0;
        n_vec++;
        if (AckA !== 1'b1 || Err !== 1'b0 || RData !== 32'h0BADF00D) begin
            n_err++;
            $display("FAIL t4_done_wins: got acka=%b err=%b rdata=%h want 1 0 0badf00d",
                     AckA, Err, RData);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        bit ok;
        int a0, b0;
        ReqA = 1; WeA = 1; AddrA = 32'h400; WDataA = 32'h77;
        wait_start(12, ok);
        ReqA = 0;
        tick();
        tick();
        tick();
        a0 = n_acka; b0 = n_ackb;
        reset = 1;
        tick();
        n_vec++;
        if ({Sel, MemStart, MemWe, AckA, AckB, Err, Busy} !== 7'b0 ||
            MemAddr !== 32'h0 || MemWData !== 32'h0 || RData !== 32'h0) begin
            n_err++;
            $display("FAIL t5_abort_outputs: got ctl=%b addr=%h wdata=%h rdata=%h want all zero",
                     {Sel, MemStart, MemWe, AckA, AckB, Err, Busy}, MemAddr, MemWData, RData);
        end
        reset = 0;
        tick();
        tick();
        tick();
        n_vec++;
        if (n_acka != a0 || n_ackb != b0 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL t5_no_ack: got acka+=%0d ackb+=%0d busy=%b want 0 0 0",
                     n_acka - a0, n_ackb - b0, Busy);
        end
        ReqA = 1; ReqB = 1; AddrA = 32'h500; AddrB = 32'h600;
        wait_start(12, ok);
        ReqA = 0; ReqB = 0;
        n_vec++;
        if (!ok || Sel !== 1'b0 || MemAddr !== 32'h500) begin
            n_err++;
            $display("FAIL t5_tie_a_first: got ok=%0d sel=%b addr=%h want 1 0 00000500", ok, Sel, MemAddr);
        end
        tick();
        MemDone = 1;
        tick();
        MemDone = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int last_c, b0;
        b0 = n_ackb;
        last_c = 0;
        ReqB = 1; WeB = 0; AddrB = 32'h700;
        for (int g = 0; g < 3; g++) begin
            wait_start(12, ok);
            MemDone = 0;
            n_vec++;
            if (!ok || Sel !== 1'b1) begin
                n_err++;
                $display("FAIL t6_start%0d: got ok=%0d sel=%b want 1 1", g, ok, Sel);
            end
            if (g > 0) begin
                n_vec++;
                if (cyc - last_c != 5) begin
                    n_err++;
                    $display("FAIL t6_spacing%0d: got %0d want 5", g, cyc - last_c);
                end
            end
            last_c = cyc;
            tick();
            MemDone = 1;
            tick();
            n_vec++;
            if (AckB !== 1'b1 || AckA !== 1'b0) begin
                n_err++;
                $display("FAIL t6_ack%0d: got ackb=%b acka=%b want 1 0", g, AckB, AckA);
            end
            // MemDone stays high through the following IDLE cycles and must be ignored
        end
        ReqB = 0;
        for (int i = 0; i < 4; i++) tick();
        MemDone = 0;
        n_vec++;
        if (n_ackb - b0 != 3 || Busy !== 1'b0 || AckB !== 1'b0) begin
            n_err++;
            $display("FAIL t6_ack_count: got ackb=%0d busy=%b want 3 0", n_ackb - b0, Busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_alternate();
        test_timeout();
        test_done_at_timeout();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one shared 32-bit memory/resource port.
- Owns the select line of the 2:1 datapath mux in front of the port: Sel=0 passes requester A, Sel=1 passes requester B.
- Latches the winner's command, issues a one-cycle start pulse, waits for completion or a timeout, then returns read data and acknowledges the winner.

Parameters:
TIMEOUT, 16, number of WAIT cycles without MemDone before abort; must be in the range 1 to 2^CNT_W-1.
CNT_W, 5, width of the WAIT-cycle counter.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
ReqA  input  1  requester A transaction request (level)
WeA  input  1  A write enable (1=write, 0=read)
AddrA  input  32  A address
WDataA  input  32  A write data (signed)
ReqB  input  1  requester B request (level)
WeB  input  1  B write enable
AddrB  input  32  B address
WDataB  input  32  B write data (signed)
MemDone  input  1  resource completion strobe
MemRData  input  32  resource read data, valid with MemDone
Sel  output  1  mux select / current owner (0=A, 1=B), registered
MemStart  output  1  one-cycle start pulse to resource
MemWe  output  1  latched write enable
MemAddr  output  32  latched address
MemWData  output  32  latched write data
AckA  output  1  one-cycle completion to A
AckB  output  1  one-cycle completion to B
RData  output  32  read data returned with Ack
Err  output  1  timeout flag, valid only with Ack
Busy  output  1  high in ISSUE, WAIT and DONE

Behaviour:
- Reset (synchronous, dominates all other inputs):
  - state=IDLE; every output 0; counter 0; LastSel=1, so A wins the first tie.
  - A reset in any state aborts the transaction with no Ack.
- IDLE:
  - Request sampling: ReqA/ReqB are sampled only in IDLE.
  - Masking: a requester whose Ack was high in the previous cycle is masked for this IDLE cycle.
  - Winner selection: the only unmasked requester, or on a tie the requester with Sel != LastSel.
  - On a win: latch Sel, MemWe, MemAddr, MemWData from the winner's inputs; go to ISSUE.
  - With no request: stay in IDLE; Sel, MemAddr, MemWData and MemWe hold their last values.
- ISSUE:
  - MemStart=1 for exactly this cycle.
  - Counter cleared; go to WAIT.
- WAIT:
  - MemDone=1: RData<=MemRData, Err<=0, go to DONE.
  - MemDone=0 and counter==TIMEOUT-1: RData<=0, Err<=1, go to DONE.
  - MemDone=0 otherwise: counter+1, stay in WAIT.
  - MemDone and the timeout in the same cycle: MemDone wins, Err=0.
- DONE:
  - AckA or AckB (per Sel) =1 for this cycle only; Err valid this cycle and 0 otherwise.
  - LastSel<=Sel; go to IDLE.
- MemDone outside WAIT is ignored.
- Latched outputs: Sel, MemWe, MemAddr, MemWData stay stable from ISSUE through DONE.
  - Requester inputs may change after the grant with no effect.
  - Dropping Req mid-transaction does not cancel it; Ack is still issued.
- RData holds its value until the next DONE.
- Latency:
  - Req sampled at edge k.
  - ISSUE in cycle k+1.
  - WAIT from k+2.
  - With MemDone in the first WAIT cycle, Ack in k+3.
  - Minimum issue-to-issue spacing is 4 cycles with the other requester pending, and 5 cycles for the same requester because of the mask cycle.
- Fairness: with both requesters held high, grants strictly alternate A, B, A, B.

Test Plan:
1. After reset: ReqA=1, WeA=0, AddrA=0x10; MemDone=1 with MemRData=0xDEADBEEF in the 2nd WAIT cycle -> MemStart pulses once with Sel=0 and MemAddr=0x10; AckA one cycle; RData=0xDEADBEEF; Err=0; AckB never asserted.
2. ReqA=ReqB=1 held continuously, MemDone in the first WAIT cycle, WeB=1, WDataB=-5 -> four grants in order A, B, A, B; MemStart spacing 4 cycles; MemWData=0xFFFFFFFB with MemWe=1 during B's grants.
3. ReqB alone, MemDone never asserted, TIMEOUT=16 -> exactly 16 WAIT cycles, then AckB with Err=1 and RData=0; a following B transaction with MemDone completes with Err=0.
4. MemDone asserted in WAIT cycle 16 (the timeout cycle) -> Err=0; RData=MemRData.
5. reset asserted in the 3rd WAIT cycle of an A transaction -> next cycle all outputs 0, Busy=0, no Ack; afterwards a ReqA/ReqB tie grants A first.
6. ReqB held continuously alone, MemDone in the first WAIT cycle -> MemStart pulses spaced exactly 5 cycles; one AckB per transaction; MemDone pulses injected in IDLE are ignored (no extra Ack).
